// File: rtl/spike_imem_pkg.sv
// Shared definitions for the double-buffered spike input memory:
// register region offsets, region decode enum and buffer sizing.
package spike_imem_pkg;

  localparam logic [31:0] SHADOW_OFF = 32'h0000_0000;
  localparam logic [31:0] ACTIVE_OFF = 32'h0000_0400;
  localparam logic [31:0] STATUS_OFF = 32'h0000_0800;

  typedef enum logic [1:0] {
    REG_SHADOW,
    REG_ACTIVE,
    REG_STATUS,
    REG_NONE
  } region_e;

  function automatic int words_f(input int num_axons);
    return num_axons / 32;
  endfunction

endpackage

// File: rtl/spike_imem_bank.sv
// One core's shadow/active spike buffer pair with its tick counter.
// Shadow takes byte-lane writes; a tick copies shadow into active.
module spike_imem_bank
  import spike_imem_pkg::*;
#(
  parameter int NUM_AXONS     = 256,
  parameter bit CLEAR_ON_TICK = 1'b1,
  localparam int W     = words_f(NUM_AXONS),
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [3:0]           wr_sel,
  input  logic [31:0]          wr_data,
  input  logic                 tick,
  output logic [NUM_AXONS-1:0] shadow_q,
  output logic [NUM_AXONS-1:0] active_q,
  output logic [15:0]          tick_cnt
);

  logic [NUM_AXONS-1:0] shadow_nxt;

  // Clear is applied before the write so a write landing on the tick edge survives.
  always_comb begin
    shadow_nxt = shadow_q;
    if (tick && CLEAR_ON_TICK) shadow_nxt = '0;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_sel[b]) shadow_nxt[32*int'(wr_idx) + 8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      tick_cnt <= '0;
    end else begin
      shadow_q <= shadow_nxt;
      if (tick) begin
        active_q <= shadow_q;
        tick_cnt <= tick_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/spike_imem_db.sv
// Wishbone slave front end for per-core double-buffered axon spike memory:
// address decode, single-beat ack, registered read mux and bank array.
module spike_imem_db
  import spike_imem_pkg::*;
#(
  parameter int          NUM_CORES     = 2,
  parameter int          NUM_AXONS     = 256,
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter logic [31:0] CORE_STRIDE   = 32'h0001_0000,
  parameter bit          CLEAR_ON_TICK = 1'b1
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_ni,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_stb_i,
  input  logic                           wbs_we_i,
  input  logic [3:0]                     wbs_sel_i,
  input  logic [31:0]                    wbs_adr_i,
  input  logic [31:0]                    wbs_dat_i,
  output logic                           wbs_ack_o,
  output logic [31:0]                    wbs_dat_o,
  input  logic [NUM_CORES-1:0]           core_en_i,
  input  logic [NUM_CORES-1:0]           core_tick_i,
  output logic [NUM_CORES*NUM_AXONS-1:0] spike_axon_o
);

  localparam int          W         = words_f(NUM_AXONS);
  localparam int          IDX_W     = (W > 1) ? $clog2(W) : 1;
  localparam int          CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [31:0] BUF_BYTES = 32'(4 * W);

  logic [31:0]       off;
  logic [31:0]       core_num;
  logic [31:0]       reg_off;
  logic              hit;
  logic [CORE_W-1:0] core_sel;
  region_e           region;
  logic [IDX_W-1:0]  word_idx;
  logic              accept;
  logic [31:0]       rd_data;

  logic [NUM_CORES-1:0][NUM_AXONS-1:0] shadow_all;
  logic [NUM_CORES-1:0][NUM_AXONS-1:0] active_all;
  logic [NUM_CORES-1:0][15:0]          tick_all;

  assign off      = wbs_adr_i - BASE_ADDR;
  assign core_num = off / CORE_STRIDE;
  assign reg_off  = off % CORE_STRIDE;
  assign hit      = core_num < 32'(NUM_CORES);
  assign core_sel = CORE_W'(core_num);

  always_comb begin
    region   = REG_NONE;
    word_idx = '0;
    if (hit) begin
      if (reg_off < SHADOW_OFF + BUF_BYTES) begin
        region   = REG_SHADOW;
        word_idx = IDX_W'((reg_off - SHADOW_OFF) >> 2);
      end else if (reg_off >= ACTIVE_OFF && reg_off < ACTIVE_OFF + BUF_BYTES) begin
        region   = REG_ACTIVE;
        word_idx = IDX_W'((reg_off - ACTIVE_OFF) >> 2);
      end else if (reg_off[31:2] == STATUS_OFF[31:2]) begin
        region = REG_STATUS;
      end
    end
  end

  // Classic single-beat handshake: a held strobe is accepted on alternate cycles.
  assign accept = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_bank
    logic wr_en;
    assign wr_en = accept & wbs_we_i & (region == REG_SHADOW) & core_en_i[c]
                 & (core_sel == CORE_W'(c));

    spike_imem_bank #(
      .NUM_AXONS     (NUM_AXONS),
      .CLEAR_ON_TICK (CLEAR_ON_TICK)
    ) u_bank (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .wr_en     (wr_en),
      .wr_idx    (word_idx),
      .wr_sel    (wbs_sel_i),
      .wr_data   (wbs_dat_i),
      .tick      (core_tick_i[c]),
      .shadow_q  (shadow_all[c]),
      .active_q  (active_all[c]),
      .tick_cnt  (tick_all[c])
    );
  end

  assign spike_axon_o = active_all;

  always_comb begin
    rd_data = '0;
    case (region)
      REG_SHADOW: rd_data = shadow_all[core_sel][32*int'(word_idx) +: 32];
      REG_ACTIVE: rd_data = active_all[core_sel][32*int'(word_idx) +: 32];
      REG_STATUS: rd_data = {16'h0000, tick_all[core_sel]};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= accept;
      if (accept && !wbs_we_i) wbs_dat_o <= rd_data;
    end
  end

endmodule

// File: doc/spike_imem_db.md
# spike_imem_db

Double-buffered, parametrised axon-spike input memory for `NUM_CORES` SNN cores, mapped as a Wishbone slave. Firmware writes the next timestep's input spikes into a per-core shadow buffer. On each core's tick, the shadow buffer is copied atomically into the active buffer that drives that core's axon inputs. The block sits between the Wishbone bus and the cores' axon inputs, and adds readback, a tick counter and optional clear-on-tick.

## Interface
- `NUM_CORES`, default 2: number of cores / buffer pairs.
- `NUM_AXONS`, default 256: axons per core; must be a multiple of 32. `W = NUM_AXONS/32` words.
- `BASE_ADDR`, default 32'h8000_0000: byte address of core 0 region.
- `CORE_STRIDE`, default 32'h0001_0000: byte distance between core regions.
- `CLEAR_ON_TICK`, default 1: zero the shadow buffer after each tick copy.

Ports:
- `wb_clk_i`  in  1: the single clock; all logic is on the rising edge.
- `wb_rst_ni`  in  1: reset, asynchronous and active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each: Wishbone classic cycle, strobe and write enable.
- `wbs_sel_i`  in  4: byte lane enables.
- `wbs_adr_i`  in  32: byte address.
- `wbs_dat_i`  in  32: write data.
- `wbs_ack_o`  out  1: transfer acknowledge.
- `wbs_dat_o`  out  32: read data.
- `core_en_i`  in  NUM_CORES: per-core write enable for shadow buffers.
- `core_tick_i`  in  NUM_CORES: per-core timestep pulse.
- `spike_axon_o`  out  NUM_CORES*NUM_AXONS: active buffers; core c occupies `[c*NUM_AXONS +: NUM_AXONS]`.

## Operation
- Decode: `off = adr - BASE_ADDR`; `c = off / CORE_STRIDE`; `r = off % CORE_STRIDE`. The address hits only if `c < NUM_CORES`.
- Region map for `r`:
  - 0x000..4W-1: shadow buffer, read/write.
  - 0x400..0x400+4W-1: active buffer, read-only.
  - 0x800: STATUS, read-only, `{16'b0, tick_cnt[15:0]}`.
  - Word index is `r[..:2]`; `adr[1:0]` is ignored.
- Bit mapping: shadow/active word k bits [31:0] correspond to axons `32k+31 .. 32k`.
- Write to shadow: applies per byte lane from `wbs_sel_i`, and only if `core_en_i[c]`. With the core disabled, the write is dropped but still acked.
- Writes to active, STATUS or unmapped addresses are ignored and acked.
- Reads from unmapped addresses are acked and return 0.
- Tick on core c:
  - active_c <= shadow_c (pre-write value).
  - tick_cnt_c increments and wraps at 0xFFFF -> 0.
  - If `CLEAR_ON_TICK`, shadow_c <= 0.
- Tick and shadow write to the same core in the same cycle:
  - active gets the old shadow.
  - The new shadow is (cleared or old) with the written bytes applied, so the write is never lost.
- Ticks on different cores are independent; simultaneous ticks on all cores are all honoured.

## Timing
- Ack: `wbs_ack_o <= cyc & stb & ~wbs_ack_o`.
  - Exactly one ack pulse, one cycle after the strobe is sampled.
  - A held strobe yields ack on alternate cycles (classic single-beat).
- `wbs_dat_o` is registered, valid in the ack cycle, and holds its value otherwise.
- A write takes effect at the same edge that raises ack; readback of the same word in the next transfer returns the new data.
- `spike_axon_o` updates at the edge sampling `core_tick_i`, i.e. visible the cycle after the tick pulse. It is stable between ticks.
- Reset (asynchronous assert, any time, including mid-transfer) clears:
  - `wbs_ack_o`, `wbs_dat_o`
  - all shadow and active buffers, so `spike_axon_o` = 0
  - all tick counters
- A transfer in flight at reset is lost. The master must re-issue it.

## Structure
- Package `spike_imem_pkg`:
  - region offset constants (`SHADOW_OFF`, `ACTIVE_OFF`, `STATUS_OFF`)
  - `region_e` enum {REG_SHADOW, REG_ACTIVE, REG_STATUS, REG_NONE}
  - `words_f(NUM_AXONS)` function
- Sub-module `spike_imem_bank`, one instance per core via generate. It holds shadow/active/tick_cnt, applies byte-lane writes, the tick copy and the clear.
- The top level contains the address decode, ack logic and read mux.

## Test plan
- Write core 0 word 0 = 0xDEADBEEF, sel=4'hF -> ack 1 cycle later; shadow read = 0xDEADBEEF; `spike_axon_o[31:0]` stays 0 until `core_tick_i[0]`, then = 0xDEADBEEF the next cycle; shadow reads 0 after the tick.
- Byte lanes: word 0 = 0xFFFFFFFF, then write 0x12345678 with sel=4'b0101 -> readback 0xFF34FF78.
- `core_en_i[1]`=0, write 0xA5A5A5A5 to 0x8001_0004 -> ack asserted, readback 0, core 1 active unchanged.
- Same-cycle tick and write of 0x0000_00FF to core 0 word 1 (old shadow 0x11) -> active word 1 = 0x11, shadow word 1 = 0xFF, STATUS = 1.
- Read 0x8002_0000 (core 2, NUM_CORES=2) and 0x8000_0900 -> ack, data 0; 65536 ticks -> STATUS wraps to 0.
- Assert `wb_rst_ni`=0 mid-strobe after loading core 1 -> ack, data and all of `spike_axon_o` are 0 immediately; after release, STATUS = 0.
